// File: rtl/ks_serial_wide_adder.sv
// ks_serial_wide_adder
//   Byte-serial wide adder: one 8-bit Kogge-Stone carry chain is reused once
//   per cycle, least significant byte first, so an operand of 8*NBYTES bits
//   takes NBYTES cycles to sum. Valid/ready handshake on both sides.
//
//   Parameters
//     NBYTES       operand width in bytes (2..16)
//   Ports
//     clk          clock, rising edge
//     rst          synchronous active-high reset
//     start_valid  operands offered
//     start_ready  block idle and can accept operands
//     a, b, cin    operands and carry-in, sampled only on the accept edge
//     res_valid    sum/cout valid, held until res_ready
//     res_ready    consumer takes the result
//     sum, cout    a + b + cin and carry out of the MSB
//     overflow     two's-complement overflow (only with KS_SERIAL_OVF_EN)
//
//   Build option: define KS_SERIAL_OVF_EN to add the overflow port.

// 8-bit Kogge-Stone carry network; c_o[i] is the carry out of bit i.
module kogge_stone_adder_carry_chain (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       c0,
    output logic [7:0] c_o
);
    logic [7:0] g;
    logic [7:0] p;
    logic [7:0] g_n;
    logic [7:0] p_n;

    // c0 is folded into bit 0's generate, so the prefix result at bit i is
    // directly the carry out of bit i.
    always_comb begin
        g = a & b;
        p = a ^ b;
        g[0] = g[0] | (p[0] & c0);
        g_n = '0;
        p_n = '0;
        for (int unsigned lvl = 0; lvl < 3; lvl++) begin
            for (int unsigned i = 0; i < 8; i++) begin
                if (i >= (1 << lvl)) begin
                    g_n[i] = g[i] | (p[i] & g[i - (1 << lvl)]);
                    p_n[i] = p[i] & p[i - (1 << lvl)];
                end else begin
                    g_n[i] = g[i];
                    p_n[i] = p[i];
                end
            end
            g = g_n;
            p = p_n;
        end
        c_o = g;
    end
endmodule

module ks_serial_wide_adder #(
    parameter int unsigned NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_valid,
    output logic                  start_ready,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [8*NBYTES-1:0]   b,
    input  logic                  cin,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [8*NBYTES-1:0]   sum,
    output logic                  cout
`ifdef KS_SERIAL_OVF_EN
    ,
    output logic                  overflow
`endif
);
    localparam int unsigned IW = $clog2(NBYTES) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [8*NBYTES-1:0] a_q;
    logic [8*NBYTES-1:0] b_q;
    logic [8*NBYTES-1:0] sum_q;
    logic                carry_q;
    logic                cout_q;
    logic [IW-1:0]       idx_q;
    logic                last_byte;

    logic [7:0] a_byte;
    logic [7:0] b_byte;
    logic [7:0] c_o;
    logic [7:0] sum_byte;

    assign a_byte    = a_q[{idx_q, 3'b000} +: 8];
    assign b_byte    = b_q[{idx_q, 3'b000} +: 8];
    assign last_byte = (idx_q == IW'(NBYTES - 1));

    kogge_stone_adder_carry_chain u_chain (
        .a   (a_byte),
        .b   (b_byte),
        .c0  (carry_q),
        .c_o (c_o)
    );

    // Carry into bit i is the carry out of bit i-1 (c0 for bit 0).
    assign sum_byte = a_byte ^ b_byte ^ {c_o[6:0], carry_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        start_ready = 1'b0;
        res_valid   = 1'b0;
        unique case (state_q)
            IDLE: begin
                start_ready = 1'b1;
                if (start_valid) state_d = RUN;
            end
            RUN: begin
                if (last_byte) state_d = DONE;
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef KS_SERIAL_OVF_EN
    logic ovf_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
`ifdef KS_SERIAL_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            if (state_q == IDLE && start_valid) begin
                a_q     <= a;
                b_q     <= b;
                carry_q <= cin;
                idx_q   <= '0;
            end
            if (state_q == RUN) begin
                sum_q[{idx_q, 3'b000} +: 8] <= sum_byte;
                carry_q <= c_o[7];
                idx_q   <= idx_q + 1'b1;
                if (last_byte) begin
                    cout_q <= c_o[7];
`ifdef KS_SERIAL_OVF_EN
                    ovf_q  <= c_o[7] ^ c_o[6];
`endif
                end
            end
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef KS_SERIAL_OVF_EN
    assign overflow = ovf_q;
`endif
endmodule
